lcd_reader: RTL and testbench
=============================

# lcd_reader

HD44780-compatible LCD read controller, the read-side counterpart of the team's LCD write path on the DE-board character LCD. On a host request it either reads the busy flag and address counter, or reads one DDRAM character at a given address. For a DDRAM read it sets the address, polls the busy flag, then reads the data. It owns `LCD_DATA` tri-state control while active. Bus sharing with the writer is handled by the integrator's mux, which is selected on `oBUSY`.

## Interface
- `T_AS`, default 2: address setup cycles; RS/RW valid with EN low before EN rises.
- `T_EN`, default 25: EN high cycles (500 ns at 50 MHz).
- `T_REC`, default 25: EN low recovery cycles after the falling edge; RS/RW are held.
- `BUSY_TIMEOUT`, default 100000: maximum cycles spent polling BF (2 ms).
- `iCLK`  in  1  system clock, 50 MHz.
- `iRST_N`  in  1  reset, synchronous and active-low.
- `iREQ`  in  1  request; sampled only in IDLE.
- `iMODE`  in  1  0 = status read (BF+AC); 1 = DDRAM read at `iADDR`.
- `iADDR`  in  7  DDRAM address; latched at acceptance and passed unchecked.
- `oBUSY`  out  1  high from the cycle after acceptance until `oDONE`, inclusive.
- `oDONE`  out  1  one-cycle completion pulse.
- `oDATA`  out  8  last status byte (mode 0) or character (mode 1).
- `oAC`  out  7  address counter from the last status read.
- `oERR`  out  1  busy timeout; sticky until the next accepted request.
- `LCD_DATA`  inout  8  driven only during the write phase of a write bus cycle, otherwise high-Z.
- `LCD_RW`  out  1  0 = write, 1 = read.
- `LCD_EN`  out  1  enable strobe.
- `LCD_RS`  out  1  0 = command/status, 1 = data.

## Operation
- Reset values:
  - `LCD_EN`=0, `LCD_RW`=1, `LCD_RS`=0, `LCD_DATA` high-Z.
  - `oBUSY`=0, `oDONE`=0, `oERR`=0, `oDATA`=0, `oAC`=0.
  - FSM in IDLE.
- Bus cycle sub-machine, one transaction with inputs (rs, rw, wdata):
  - SETUP for `T_AS` cycles: EN=0, RS/RW valid; data driven if rw=0.
  - EN_HI for `T_EN` cycles.
  - EN_LO for `T_REC` cycles, RS/RW held.
  - If rw=1, `LCD_DATA` is registered on the last EN_HI cycle.
  - RS/RW/data change only while EN=0.
- Top FSM states: IDLE, WR_ADDR, POLL, RD_DATA, STAT, FIN.
- IDLE:
  - `iREQ`=1 latches `iMODE`/`iADDR` and clears `oERR`.
  - Goes to STAT (mode 0) or WR_ADDR (mode 1).
- STAT: one status read (RS=0, RW=1); then `oAC`=rd[6:0] and `oDATA`=rd; go to FIN.
- WR_ADDR: one write of command `8'h80 | addr` (RS=0, RW=0); go to POLL.
- POLL:
  - Repeated status reads, with `oAC` updated after each.
  - rd[7]=0 → RD_DATA.
  - Poll cycle counter ≥ `BUSY_TIMEOUT` at the end of a bus cycle → set `oERR`=1 and go to FIN. `oDATA` is unchanged.
- RD_DATA: one read with RS=1, RW=1; `oDATA`=rd; go to FIN.
- FIN: `oDONE`=1 for one cycle; `oBUSY` drops the next cycle; return to IDLE.
- `iREQ` while not in IDLE is ignored, and the latched mode/address are unaffected.
- The HD44780 auto-increments AC after a data read. `oAC` reflects the last poll, not the post-read value.

## Timing
- Let B = `T_AS`+`T_EN`+`T_REC` (52 cycles with default parameters).
- Mode 0: `iREQ` sampled high at edge N.
  - `oBUSY`=1 from N+1.
  - `oDONE` at N+B+2.
  - `oBUSY`=0 at N+B+3.
  - The next request is acceptable at N+B+3.
- Mode 1 with k status polls: `oDONE` at N+(k+2)·B+2.
- Reset mid-operation: on the next edge all outputs return to reset values and `LCD_EN` falls immediately. No partial result is reported.
- EN high width is exactly `T_EN` cycles. EN low between consecutive bus cycles is ≥ `T_REC`+`T_AS` cycles.

## Structure
- Package `lcd_pkg` holds:
  - the state enum;
  - `CMD_SET_DDRAM` = 8'h80;
  - `BF_BIT` = 7;
  - the default timing constants, shared with the writer.
- Sub-module `lcd_bus_cycle` implements the single timed transaction, with:
  - inputs: start, rs, rw, wdata;
  - outputs: rdata, done, pins, and the data output enable.
- The top level is the sequencer plus the output registers.

## Test plan
- Mode 0, LCD model returns 8'h25:
  - `oAC`=7'h25, `oDATA`=8'h25, `oERR`=0.
  - `oDONE` exactly 54 cycles after `iREQ`.
- Mode 1, `iADDR`=7'h40, model BF=1 for 3 polls then data 8'h41:
  - bus shows write 8'hC0 (RS=0, RW=0), then 4 status reads, then one read with RS=1.
  - `oDATA`=8'h41, `oDONE` at 6·52+2 cycles.
- `BUSY_TIMEOUT`=1000 with BF stuck at 1:
  - `oERR`=1 with an `oDONE` pulse; EN=0 and bus high-Z afterwards.
  - Next request clears `oERR`.
- Second `iREQ` (`iADDR`=7'h05) during a busy mode 1 at 7'h40: ignored, and only the 8'hC0 command appears.
- `iRST_N` low during EN_HI: next edge EN=0, RW=1, `oBUSY`=0, bus high-Z; a following mode 0 request completes normally.
- Assertion throughout all tests:
  - RS/RW never change while EN=1.
  - `LCD_DATA` is driven only when RW=0.
  - `oDONE` is never two cycles wide.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, command codes and default bus timing for the character LCD
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, POLL, RD_DATA, STAT, FIN} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EN_HI, PH_EN_LO} phase_t;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam int BF_BIT = 7;
  localparam int T_AS_DEF = 2;
  localparam int T_EN_DEF = 25;
  localparam int T_REC_DEF = 25;
  localparam int BUSY_TIMEOUT_DEF = 100000;
  function automatic logic is_bus(state_t s);
    return s inside {WR_ADDR, POLL, RD_DATA, STAT};
  endfunction
endpackage

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: one timed HD44780 bus transaction (setup, enable high, recovery)
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_AS  = T_AS_DEF,
  parameter int T_EN  = T_EN_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic [7:0] data_in,
  output logic [7:0] rdata,
  output logic       done,
  output logic       idle,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] data_out,
  output logic       data_oe
);
  phase_t phase;
  logic [15:0] cnt;
  always_comb begin
    idle = phase == PH_IDLE;
    done = phase == PH_EN_LO && cnt == 16'(T_REC - 1);
    data_oe = !lcd_rw && !idle;
  end
  // a start on the last recovery cycle chains the next transaction with no idle gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      cnt <= '0;
      lcd_en <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b1;
      data_out <= '0;
      rdata <= '0;
    end else if (start && (idle || done)) begin
      phase <= PH_SETUP;
      cnt <= '0;
      lcd_rs <= rs;
      lcd_rw <= rw;
      data_out <= wdata;
    end else begin
      case (phase)
        PH_SETUP: begin
          cnt <= cnt == 16'(T_AS - 1) ? '0 : cnt + 16'd1;
          phase <= cnt == 16'(T_AS - 1) ? PH_EN_HI : PH_SETUP;
          lcd_en <= cnt == 16'(T_AS - 1);
        end
        PH_EN_HI: begin
          cnt <= cnt == 16'(T_EN - 1) ? '0 : cnt + 16'd1;
          phase <= cnt == 16'(T_EN - 1) ? PH_EN_LO : PH_EN_HI;
          lcd_en <= cnt != 16'(T_EN - 1);
          if (cnt == 16'(T_EN - 1) && lcd_rw) rdata <= data_in;
        end
        PH_EN_LO: begin
          cnt <= done ? '0 : cnt + 16'd1;
          phase <= done ? PH_IDLE : PH_EN_LO;
          if (done) begin
            lcd_rs <= 1'b0;
            lcd_rw <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read sequencer for status (BF+AC) or one DDRAM character
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_AS         = T_AS_DEF,
  parameter int T_EN         = T_EN_DEF,
  parameter int T_REC        = T_REC_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iMODE,
  input  logic [6:0] iADDR,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oDATA,
  output logic [6:0] oAC,
  output logic       oERR,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);
  state_t state, nxt;
  logic [6:0] addr;
  logic [31:0] poll_cnt;
  logic start, bus_idle, bus_done, data_oe, timed_out;
  logic [7:0] rd, data_out;
  assign LCD_DATA = data_oe ? data_out : 'z;
  always_comb begin
    timed_out = rd[BF_BIT] && poll_cnt >= 32'(BUSY_TIMEOUT);
    nxt = state;
    case (state)
      IDLE:          nxt = iREQ ? (iMODE ? WR_ADDR : STAT) : IDLE;
      STAT, RD_DATA: nxt = bus_done ? FIN : state;
      WR_ADDR:       nxt = bus_done ? POLL : WR_ADDR;
      POLL:          nxt = !bus_done ? POLL : !rd[BF_BIT] ? RD_DATA : timed_out ? FIN : POLL;
      default:       nxt = IDLE;
    endcase
    // the next transaction is described by the state it belongs to, so it can launch on the done cycle
    start = is_bus(state) && is_bus(nxt) && (bus_idle || bus_done);
  end
  lcd_bus_cycle #(.T_AS(T_AS), .T_EN(T_EN), .T_REC(T_REC)) u_bus (
    .clk(iCLK),
    .rst_n(iRST_N),
    .start(start),
    .rs(nxt == RD_DATA),
    .rw(nxt != WR_ADDR),
    .wdata(CMD_SET_DDRAM | {1'b0, addr}),
    .data_in(LCD_DATA),
    .rdata(rd),
    .done(bus_done),
    .idle(bus_idle),
    .lcd_en(LCD_EN),
    .lcd_rs(LCD_RS),
    .lcd_rw(LCD_RW),
    .data_out(data_out),
    .data_oe(data_oe)
  );
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
      addr <= '0;
      poll_cnt <= '0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      oDATA <= '0;
      oAC <= '0;
      oERR <= 1'b0;
    end else begin
      state <= nxt;
      oDONE <= state == FIN;
      oBUSY <= state == IDLE ? iREQ : 1'b1;
      poll_cnt <= state == POLL ? poll_cnt + 32'd1 : '0;
      if (state == IDLE && iREQ) begin
        addr <= iADDR;
        oERR <= 1'b0;
      end
      if (bus_done && state inside {STAT, POLL}) oAC <= rd[6:0];
      if (bus_done && state inside {STAT, RD_DATA}) oDATA <= rd;
      if (bus_done && state == POLL && timed_out) oERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: table-driven scoreboard bench with an HD44780 bus model
module tb_lcd_reader;
  logic iCLK = 1'b0;
  logic iRST_N, iREQ, iMODE;
  logic [6:0] iADDR;
  logic oBUSY, oDONE, oERR, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] oDATA;
  logic [6:0] oAC;
  wire [7:0] LCD_DATA;
  typedef struct {
    logic mode; logic [6:0] addr; logic [6:0] ac; logic [7:0] ch;
    int bf; int nstat; logic rd;
    logic [7:0] e_data; logic [6:0] e_ac; logic e_err; int lat;
  } vec_t;
  typedef struct {logic [7:0] data; logic [6:0] ac; logic err;} res_t;
  vec_t tv[6];
  vec_t v;
  logic [9:0] bus_q[$];
  res_t res_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  int status_reads = 0, m_base = 0, m_bf = 0;
  logic [6:0] m_ac = '0;
  logic [7:0] m_ch = '0;
  logic bf;

  lcd_reader #(.BUSY_TIMEOUT(1000)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iMODE(iMODE), .iADDR(iADDR),
    .oBUSY(oBUSY), .oDONE(oDONE), .oDATA(oDATA), .oAC(oAC), .oERR(oERR),
    .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  assign bf = (status_reads - m_base) < m_bf;
  assign LCD_DATA = (LCD_EN && LCD_RW) ? (LCD_RS ? m_ch : {bf, m_ac}) : 8'hzz;

  initial forever #10 iCLK = ~iCLK;
  initial forever begin
    @(posedge iCLK);
    cyc++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // bus monitor, status-read counter for the BF model, result scoreboard, protocol checks
  initial begin
    logic en_d, done_d;
    logic [1:0] rsrw_d;
    logic [9:0] obs;
    res_t r;
    en_d = 1'b0; done_d = 1'b0; rsrw_d = 2'b01;
    forever begin
      @(negedge iCLK);
      if (LCD_EN && !en_d) begin
        obs = {LCD_RS, LCD_RW, LCD_RW ? 8'h00 : LCD_DATA};
        if (bus_q.size() == 0) check("bus_extra", {22'd0, obs}, 32'h3ff);
        else check("bus_txn", {22'd0, obs}, {22'd0, bus_q.pop_front()});
      end
      if (!LCD_EN && en_d && !LCD_RS && LCD_RW) status_reads++;
      if (oDONE && !done_d) begin
        if (res_q.size() == 0) check("done_extra", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          check("data", {24'd0, oDATA}, {24'd0, r.data});
          check("ac", {25'd0, oAC}, {25'd0, r.ac});
          check("err", {31'd0, oERR}, {31'd0, r.err});
        end
      end
      check("protocol", {29'd0, LCD_EN && en_d && ({LCD_RS, LCD_RW} != rsrw_d),
                         dut.data_oe && LCD_RW, oDONE && done_d}, 32'd0);
      en_d = LCD_EN; done_d = oDONE; rsrw_d = {LCD_RS, LCD_RW};
    end
  end

  task automatic issue(input vec_t x, input logic push_res);
    m_ac = x.ac; m_ch = x.ch; m_bf = x.bf; m_base = status_reads;
    if (x.mode) bus_q.push_back({2'b00, 8'h80 | {1'b0, x.addr}});
    for (int i = 0; i < x.nstat; i++) bus_q.push_back({2'b01, 8'h00});
    if (x.rd) bus_q.push_back({2'b11, 8'h00});
    if (push_res) res_q.push_back('{x.e_data, x.e_ac, x.e_err});
    @(negedge iCLK);
    iREQ = 1'b1; iMODE = x.mode; iADDR = x.addr;
    @(posedge iCLK);
    #1 iREQ = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, input int lat);
    while (!oDONE && cyc - t0 < 3000) begin
      @(posedge iCLK);
      #1;
    end
    check(name, cyc - t0, lat);
    repeat (3) @(posedge iCLK);
    #1;
  endtask

  initial begin
    tv[0] = '{1'b0, 7'h00, 7'h25, 8'h00, 0, 1, 1'b0, 8'h25, 7'h25, 1'b0, 54};
    tv[1] = '{1'b0, 7'h00, 7'h0a, 8'h00, 1, 1, 1'b0, 8'h8a, 7'h0a, 1'b0, 54};
    tv[2] = '{1'b1, 7'h40, 7'h40, 8'h41, 3, 4, 1'b1, 8'h41, 7'h40, 1'b0, 6 * 52 + 2};
    tv[3] = '{1'b1, 7'h7f, 7'h7f, 8'h5a, 0, 1, 1'b1, 8'h5a, 7'h7f, 1'b0, 3 * 52 + 2};
    tv[4] = '{1'b1, 7'h00, 7'h11, 8'h00, 1000000, 20, 1'b0, 8'h5a, 7'h11, 1'b1, 21 * 52 + 2};
    tv[5] = '{1'b0, 7'h00, 7'h33, 8'h00, 0, 1, 1'b0, 8'h33, 7'h33, 1'b0, 54};
    iRST_N = 1'b0; iREQ = 1'b0; iMODE = 1'b0; iADDR = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_outputs", {oBUSY, oDONE, oERR, oDATA, oAC}, 18'd0);
    check("rst_pins", {LCD_EN, LCD_RW, LCD_RS, dut.data_oe}, 4'b0100);
    @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(tv[i], 1'b1);
      wait_done($sformatf("latency%0d", i), tv[i].lat);
    end
    repeat (5) @(posedge iCLK);
    #1;
    check("err_sticky", {31'd0, oERR}, 32'd1);
    check("timeout_idle_bus", {LCD_EN, dut.data_oe, oBUSY}, 3'b000);
    issue(tv[5], 1'b1);
    wait_done("latency_clear", tv[5].lat);
    check("err_cleared", {31'd0, oERR}, 32'd0);

    v = '{1'b1, 7'h40, 7'h40, 8'h77, 1, 2, 1'b1, 8'h77, 7'h40, 1'b0, 4 * 52 + 2};
    issue(v, 1'b1);
    repeat (20) @(posedge iCLK);
    @(negedge iCLK);
    iREQ = 1'b1; iMODE = 1'b1; iADDR = 7'h05;
    @(negedge iCLK);
    iREQ = 1'b0;
    wait_done("latency_ignore", v.lat);
    repeat (60) @(posedge iCLK);
    #1;
    check("ignore_no_restart", {30'd0, oBUSY, LCD_EN}, 32'd0);

    v = '{1'b1, 7'h40, 7'h40, 8'h00, 0, 0, 1'b0, 8'h00, 7'h00, 1'b0, 0};
    issue(v, 1'b0);
    for (int c = 0; c < 100 && !LCD_EN; c++) begin
      @(posedge iCLK);
      #1;
    end
    check("rst_en_seen", {31'd0, LCD_EN}, 32'd1);
    repeat (5) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b0;
    @(posedge iCLK);
    #1;
    check("rst_mid_pins", {LCD_EN, LCD_RW, oBUSY, dut.data_oe}, 4'b0100);
    @(negedge iCLK);
    iRST_N = 1'b1;
    check("rst_bus_q", bus_q.size(), 32'd0);
    v = '{1'b0, 7'h00, 7'h12, 8'h00, 0, 1, 1'b0, 8'h12, 7'h12, 1'b0, 54};
    issue(v, 1'b1);
    wait_done("latency_after_rst", v.lat);
    check("queues_empty", bus_q.size() + res_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
